// File: rtl/fadd_prep_n36_pkg.sv
// Shared constants, operand layout and result bundle for the FADD
// operand-preparation stage.
package fadd_n36_pkg;

    localparam int FRAC_WIDTH    = 36;
    localparam int EXP_WIDTH     = 8;
    localparam int OP_WIDTH      = 1 + EXP_WIDTH + FRAC_WIDTH - 1;
    localparam int SHIFT_WIDTH   = 6;
    localparam int FAR_SHIFT_SAT = 37;
    localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;

    // Operand after unpacking: hidden bit restored, zero/denormal flushed.
    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [FRAC_WIDTH-1:0] sig;
    } unpacked_op_t;

    // Everything the downstream adders need, carried through both stages.
    typedef struct packed {
        logic                   close_path;
        logic                   exp_a_neq_b;
        logic                   far_sign;
        logic                   eff_sub;
        logic [EXP_WIDTH-1:0]   exp_f;
        logic [FRAC_WIDTH-1:0]  elarge_op;
        logic [FRAC_WIDTH-1:0]  esmall_op;
        logic [SHIFT_WIDTH-1:0] far_shift;
        logic                   special;
    } prep_t;

    // A zero exponent is treated as exponent 1 with a zero significand,
    // so exponent comparison and difference need no special case for it.
    function automatic unpacked_op_t unpack_op(input logic [OP_WIDTH-1:0] op);
        unpacked_op_t u;
        u.sign = op[OP_WIDTH-1];
        if (op[OP_WIDTH-2 -: EXP_WIDTH] == '0) begin
            u.exp = EXP_WIDTH'(1);
            u.sig = '0;
        end else begin
            u.exp = op[OP_WIDTH-2 -: EXP_WIDTH];
            u.sig = {1'b1, op[FRAC_WIDTH-2:0]};
        end
        return u;
    endfunction

endpackage

// File: rtl/fadd_prep_n36_if.sv
// Input operand channel and prepared-pair output channel of the prep stage.
interface fadd_prep_n36_if;
    import fadd_n36_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [OP_WIDTH-1:0]    op_a;
    logic [OP_WIDTH-1:0]    op_b;
    logic                   op_sub;

    logic                   out_valid;
    logic                   out_ready;
    logic                   close_path;
    logic                   exp_a_neq_b;
    logic                   far_sign;
    logic                   eff_sub;
    logic [EXP_WIDTH-1:0]   exp_f;
    logic [FRAC_WIDTH-1:0]  elarge_op;
    logic [FRAC_WIDTH-1:0]  esmall_op;
    logic [SHIFT_WIDTH-1:0] far_shift;
    logic                   special;

    // Producer of operands / consumer of prepared pairs.
    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, close_path, exp_a_neq_b, far_sign, eff_sub,
               exp_f, elarge_op, esmall_op, far_shift, special
    );

    // The prep stage itself.
    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, close_path, exp_a_neq_b, far_sign, eff_sub,
               exp_f, elarge_op, esmall_op, far_shift, special
    );
endinterface

// File: rtl/fadd_prep_n36_cmp.sv
// Combinational unpack, exponent compare, operand swap and close/far path select.
module fadd_prep_cmp_n36
    import fadd_n36_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op_a,
    input  logic [OP_WIDTH-1:0] op_b,
    input  logic                op_sub,
    output prep_t               res
);

    unpacked_op_t         ua;
    unpacked_op_t         ub;
    logic                 sign_b_eff;
    logic [EXP_WIDTH:0]   exp_diff;
    logic [EXP_WIDTH:0]   exp_diff_abs;
    logic                 a_is_large;

    // Unpack both operands, order them and derive the path controls.
    always_comb begin
        ua           = unpack_op(op_a);
        ub           = unpack_op(op_b);
        sign_b_eff   = ub.sign ^ op_sub;
        exp_diff     = {1'b0, ua.exp} - {1'b0, ub.exp};
        exp_diff_abs = exp_diff[EXP_WIDTH] ? ((EXP_WIDTH+1)'(0) - exp_diff) : exp_diff;
        // Equal exponents are ordered by significand so the close-path
        // subtraction of small from large stays non-negative.
        a_is_large   = (ua.exp > ub.exp) || ((ua.exp == ub.exp) && (ua.sig >= ub.sig));

        res             = '0;
        res.eff_sub     = ua.sign ^ sign_b_eff;
        res.exp_a_neq_b = (ua.exp != ub.exp);
        res.far_sign    = a_is_large ? ua.sign : sign_b_eff;
        res.exp_f       = a_is_large ? ua.exp  : ub.exp;
        res.elarge_op   = a_is_large ? ua.sig  : ub.sig;
        res.esmall_op   = a_is_large ? ub.sig  : ua.sig;
        res.far_shift   = (exp_diff_abs >= (EXP_WIDTH+1)'(FAR_SHIFT_SAT))
                          ? SHIFT_WIDTH'(FAR_SHIFT_SAT)
                          : exp_diff_abs[SHIFT_WIDTH-1:0];
        res.close_path  = res.eff_sub && (exp_diff_abs <= (EXP_WIDTH+1)'(1));
        res.special     = (op_a[OP_WIDTH-2 -: EXP_WIDTH] == EXP_MAX) ||
                          (op_b[OP_WIDTH-2 -: EXP_WIDTH] == EXP_MAX);
    end

endmodule

// File: rtl/fadd_prep_n36.sv
// Two-stage valid/ready pipeline around the operand-preparation logic.
// S1 holds the compared/swapped pair, S2 holds the pair presented downstream.
module fadd_prep_n36
    import fadd_n36_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    fadd_prep_n36_if.slave   bus
);

    prep_t cmp_res;
    logic  s1_v_q, s1_v_d;
    logic  s2_v_q, s2_v_d;
    prep_t s1_data_q, s1_data_d;
    prep_t s2_data_q, s2_data_d;
    logic  s1_en;
    logic  s2_en;

    fadd_prep_cmp_n36 u_cmp (
        .op_a   (bus.op_a),
        .op_b   (bus.op_b),
        .op_sub (bus.op_sub),
        .res    (cmp_res)
    );

    // Stage enables and next-state for both pipeline registers; a stage
    // advances when it is empty or the stage after it is moving.
    always_comb begin
        s2_en     = ~s2_v_q | bus.out_ready;
        s1_en     = ~s1_v_q | s2_en;
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        if (s1_en) begin
            s1_v_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d = cmp_res;
            end
        end
        if (s2_en) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_data_d = s1_data_q;
            end
        end
    end

    // Pipeline registers; reset drops any in-flight pairs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s1_data_q <= '0;
            s2_data_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
        end
    end

    assign bus.in_ready    = s1_en;
    assign bus.out_valid   = s2_v_q;
    assign bus.close_path  = s2_data_q.close_path;
    assign bus.exp_a_neq_b = s2_data_q.exp_a_neq_b;
    assign bus.far_sign    = s2_data_q.far_sign;
    assign bus.eff_sub     = s2_data_q.eff_sub;
    assign bus.exp_f       = s2_data_q.exp_f;
    assign bus.elarge_op   = s2_data_q.elarge_op;
    assign bus.esmall_op   = s2_data_q.esmall_op;
    assign bus.far_shift   = s2_data_q.far_shift;
    assign bus.special     = s2_data_q.special;

endmodule
